// File: rtl/regfile_write_arbiter_if.sv
// Write-back request/response bundle between two requesters (ALU, load unit)
// and the register-file write port, plus the pending-write scoreboard.
interface regfile_write_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic              alu_valid;
  logic [AW-1:0]     alu_addr;
  logic [DW-1:0]     alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic              mem_ready;
  logic              hold;
  logic              enable_write;
  logic [DW-1:0]     data_write;
  logic [AW-1:0]     data_write_address;
  logic [(1<<AW)-1:0] pending;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, hold,
    input  alu_ready, mem_ready, enable_write, data_write, data_write_address, pending
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, hold,
    output alu_ready, mem_ready, enable_write, data_write, data_write_address, pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: 1-entry holding buffer per requester,
// round-robin between different addresses, age order for same-address writes.
module regfile_write_arbiter_slot #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic          full,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  // load and clear never coincide: load needs empty, clear needs full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      addr <= req_addr;
      data <= req_data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input logic                clk,
  input logic                rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int NREQ = 2;   // lane 0 = ALU, lane 1 = MEM
  localparam int NREG = 1 << AW;

  logic [NREQ-1:0]         req_valid, full, load, gnt, stay;
  logic [NREQ-1:0][AW-1:0] req_addr, buf_addr;
  logic [NREQ-1:0][DW-1:0] req_data, buf_data;
  logic                    ptr, older, pick;
  logic                    enable_write;
  logic [DW-1:0]           data_write;
  logic [AW-1:0]           data_write_address;
  logic [NREG-1:0]         pending;

  assign req_valid = {bus.mem_valid, bus.alu_valid};
  assign req_addr  = {bus.mem_addr,  bus.alu_addr};
  assign req_data  = {bus.mem_data,  bus.alu_data};
  assign load      = req_valid & ~full;

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_slot
      regfile_write_arbiter_slot #(.AW(AW), .DW(DW)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load[g]),
        .clear    (gnt[g]),
        .req_addr (req_addr[g]),
        .req_data (req_data[g]),
        .full     (full[g]),
        .addr     (buf_addr[g]),
        .data     (buf_data[g])
      );
    end
  endgenerate

  // same-address pairs follow age so the register sees writes in arrival order
  always_comb begin
    pick = full[1];
    if (&full) pick = (buf_addr[0] == buf_addr[1]) ? older : ptr;
    gnt = '0;
    if (!bus.hold && |full) gnt = pick ? 2'b10 : 2'b01;
  end

  assign stay = full & ~gnt;

  // older always names the sole occupant when only one buffer is full,
  // so a hold cycle never changes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr                <= 1'b0;
      older              <= 1'b0;
      enable_write       <= 1'b0;
      data_write         <= '0;
      data_write_address <= '0;
    end else begin
      if (&stay)             older <= older;
      else if (stay[0])      older <= 1'b0;
      else if (stay[1])      older <= 1'b1;
      else if (load == 2'b10) older <= 1'b1;
      else if (load[0])      older <= 1'b0;
      enable_write <= |gnt;
      if (|gnt) begin
        ptr                <= gnt[0];
        data_write         <= buf_data[pick];
        data_write_address <= buf_addr[pick];
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++)
      if (full[i]) pending[buf_addr[i]] = 1'b1;
    if (enable_write) pending[data_write_address] = 1'b1;
  end

  assign bus.alu_ready          = ~full[0];
  assign bus.mem_ready          = ~full[1];
  assign bus.enable_write       = enable_write;
  assign bus.data_write         = data_write;
  assign bus.data_write_address = data_write_address;
  assign bus.pending            = pending;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic
// against a timestamp-based reference model.
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_write_arbiter_if bus ();
  regfile_write_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // reference model: buffers stamped with their load cycle, older = smaller stamp
  bit         m_full [2];
  logic [2:0] m_addr [2];
  logic [7:0] m_data [2];
  int         m_ts   [2];
  int         m_ptr;
  bit         m_we;
  logic [7:0] m_wd;
  logic [2:0] m_wa;
  int         cyc_no;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_addr[i] = '0; m_data[i] = '0; m_ts[i] = 0;
    end
    m_ptr = 0; m_we = 0; m_wd = '0; m_wa = '0; cyc_no = 0;
  endtask

  task automatic model_step(input bit av, input logic [2:0] aa, input logic [7:0] ad,
                            input bit mv, input logic [2:0] ma, input logic [7:0] md,
                            input bit h);
    int g;
    bit pre [2];
    g = -1;
    pre[0] = m_full[0]; pre[1] = m_full[1];
    if (!h) begin
      if (m_full[0] && m_full[1]) begin
        if (m_addr[0] == m_addr[1]) g = (m_ts[1] < m_ts[0]) ? 1 : 0;
        else g = m_ptr;
      end else if (m_full[0]) g = 0;
      else if (m_full[1]) g = 1;
    end
    m_we = (g >= 0);
    if (g >= 0) begin
      m_wd = m_data[g]; m_wa = m_addr[g]; m_full[g] = 0; m_ptr = 1 - g;
    end
    if (av && !pre[0]) begin m_full[0] = 1; m_addr[0] = aa; m_data[0] = ad; m_ts[0] = cyc_no; end
    if (mv && !pre[1]) begin m_full[1] = 1; m_addr[1] = ma; m_data[1] = md; m_ts[1] = cyc_no; end
    cyc_no++;
  endtask

  function automatic logic [7:0] m_pend();
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 2; i++) if (m_full[i]) p[m_addr[i]] = 1'b1;
    if (m_we) p[m_wa] = 1'b1;
    return p;
  endfunction

  // drive one cycle's inputs, take the edge, return at the following negedge
  task automatic cyc(input bit av, input logic [2:0] aa, input logic [7:0] ad,
                     input bit mv, input logic [2:0] ma, input logic [7:0] md,
                     input bit h);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.hold = h;
    @(posedge clk);
    model_step(av, aa, ad, mv, ma, md, h);
    @(negedge clk);
  endtask

  task automatic idle(input bit h);
    cyc(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, h);
  endtask

  task automatic do_reset();
    bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.hold = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.enable_write !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", bus.enable_write); end
    checks++; if (bus.data_write !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 00", bus.data_write); end
    checks++; if (bus.data_write_address !== 3'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", bus.data_write_address); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %0h exp 00", bus.pending); end
    checks++; if ({bus.alu_ready, bus.mem_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %0b exp 11", {bus.alu_ready, bus.mem_ready}); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    cyc(1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 0);
    checks++; if (bus.enable_write !== 1'b0) begin errors++; $display("FAIL single_e0_we got %0b exp 0", bus.enable_write); end
    checks++; if (bus.pending !== 8'h08) begin errors++; $display("FAIL single_e0_pending got %0h exp 08", bus.pending); end
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL single_e0_ready got %0b exp 0", bus.alu_ready); end
    idle(0);
    checks++; if ({bus.enable_write, bus.data_write_address, bus.data_write} !== {1'b1, 3'd3, 8'h5A})
      begin errors++; $display("FAIL single_e1_write got %0b/%0d/%0h exp 1/3/5a", bus.enable_write, bus.data_write_address, bus.data_write); end
    checks++; if (bus.pending !== 8'h08) begin errors++; $display("FAIL single_e1_pending got %0h exp 08", bus.pending); end
    idle(0);
    checks++; if ({bus.enable_write, bus.data_write} !== {1'b0, 8'h5A}) begin errors++; $display("FAIL single_e2_we got %0b/%0h exp 0/5a", bus.enable_write, bus.data_write); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL single_e2_pending got %0h exp 00", bus.pending); end
  endtask

  task automatic test_contention();
    do_reset();
    cyc(1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0);
    checks++; if (bus.pending !== 8'h06) begin errors++; $display("FAIL cont_pending got %0h exp 06", bus.pending); end
    idle(0);
    checks++; if ({bus.enable_write, bus.data_write_address, bus.data_write} !== {1'b1, 3'd1, 8'h11})
      begin errors++; $display("FAIL cont_first got %0b/%0d/%0h exp 1/1/11", bus.enable_write, bus.data_write_address, bus.data_write); end
    // new ALU entry under hold; pointer now favours MEM
    cyc(1, 3'd4, 8'h44, 0, 3'd0, 8'h00, 1);
    checks++; if ({bus.enable_write, bus.data_write} !== {1'b0, 8'h11}) begin errors++; $display("FAIL cont_hold got %0b/%0h exp 0/11", bus.enable_write, bus.data_write); end
    idle(0);
    checks++; if ({bus.enable_write, bus.data_write_address, bus.data_write} !== {1'b1, 3'd2, 8'h22})
      begin errors++; $display("FAIL cont_mem_first got %0b/%0d/%0h exp 1/2/22", bus.enable_write, bus.data_write_address, bus.data_write); end
    idle(0);
    checks++; if ({bus.enable_write, bus.data_write_address, bus.data_write} !== {1'b1, 3'd4, 8'h44})
      begin errors++; $display("FAIL cont_alu_second got %0b/%0d/%0h exp 1/4/44", bus.enable_write, bus.data_write_address, bus.data_write); end
  endtask

  task automatic test_same_addr();
    do_reset();
    cyc(0, 3'd0, 8'h00, 1, 3'd5, 8'hAA, 0);
    cyc(1, 3'd5, 8'hBB, 0, 3'd0, 8'h00, 1);
    checks++; if ({bus.enable_write, bus.pending} !== {1'b0, 8'h20}) begin errors++; $display("FAIL same_hold got %0b/%0h exp 0/20", bus.enable_write, bus.pending); end
    idle(1);
    idle(0);
    checks++; if ({bus.enable_write, bus.data_write_address, bus.data_write} !== {1'b1, 3'd5, 8'hAA})
      begin errors++; $display("FAIL same_older got %0b/%0d/%0h exp 1/5/aa", bus.enable_write, bus.data_write_address, bus.data_write); end
    idle(0);
    checks++; if ({bus.enable_write, bus.data_write} !== {1'b1, 8'hBB}) begin errors++; $display("FAIL same_younger got %0b/%0h exp 1/bb", bus.enable_write, bus.data_write); end
    idle(0);
    checks++; if (bus.pending[5] !== 1'b0) begin errors++; $display("FAIL same_pending got %0b exp 0", bus.pending[5]); end
  endtask

  task automatic test_back_to_back();
    int  n;
    bit  rdy;
    n = 0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      rdy = bus.alu_ready;
      checks++; if (rdy !== ((k % 2) == 0)) begin errors++; $display("FAIL b2b_ready k=%0d got %0b exp %0b", k, rdy, (k % 2) == 0); end
      cyc(1, n[2:0], 8'(8'h30 + n), 0, 3'd0, 8'h00, 0);
      if (rdy) n++;
      checks++; if (bus.enable_write !== ((k % 2) == 1)) begin errors++; $display("FAIL b2b_we k=%0d got %0b exp %0b", k, bus.enable_write, (k % 2) == 1); end
      if (k % 2 == 1) begin
        checks++; if (bus.data_write !== 8'(8'h30 + k / 2)) begin errors++; $display("FAIL b2b_data k=%0d got %0h exp %0h", k, bus.data_write, 8'(8'h30 + k / 2)); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cyc(1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0);
    idle(0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.enable_write, bus.pending} !== {1'b0, 8'h00}) begin errors++; $display("FAIL mid_async got %0b/%0h exp 0/00", bus.enable_write, bus.pending); end
    checks++; if ({bus.alu_ready, bus.mem_ready} !== 2'b11) begin errors++; $display("FAIL mid_ready got %0b exp 11", {bus.alu_ready, bus.mem_ready}); end
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      idle(0);
      checks++; if (bus.enable_write !== 1'b0) begin errors++; $display("FAIL mid_ghost k=%0d got %0b exp 0", k, bus.enable_write); end
    end
    cyc(1, 3'd3, 8'h33, 1, 3'd4, 8'h44, 0);
    idle(0);
    checks++; if ({bus.data_write_address, bus.data_write} !== {3'd3, 8'h33}) begin errors++; $display("FAIL mid_alu_first got %0d/%0h exp 3/33", bus.data_write_address, bus.data_write); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 3)), 8'($urandom),
          ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 3)), 8'($urandom),
          ($urandom_range(0, 3) == 0));
      checks++; if (bus.enable_write !== m_we) begin errors++; $display("FAIL rnd_we k=%0d got %0b exp %0b", k, bus.enable_write, m_we); end
      checks++; if ({bus.data_write_address, bus.data_write} !== {m_wa, m_wd})
        begin errors++; $display("FAIL rnd_write k=%0d got %0d/%0h exp %0d/%0h", k, bus.data_write_address, bus.data_write, m_wa, m_wd); end
      checks++; if (bus.pending !== m_pend()) begin errors++; $display("FAIL rnd_pending k=%0d got %0h exp %0h", k, bus.pending, m_pend()); end
      checks++; if ({bus.alu_ready, bus.mem_ready} !== {!m_full[0], !m_full[1]})
        begin errors++; $display("FAIL rnd_ready k=%0d got %0b exp %0b", k, {bus.alu_ready, bus.mem_ready}, {!m_full[0], !m_full[1]}); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_same_addr();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
